// File: rtl/riscv_pkg.sv
// Shared encodings for the pipelined RISC-V control path: opcodes,
// ALU operations, immediate formats, result selects and ALU decode classes.
package riscv_pkg;

  localparam int unsigned OP_W      = 7;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned IMMSRC_W  = 3;
  localparam int unsigned RESSRC_W  = 2;
  localparam int unsigned ALUOP_W   = 2;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_IALU  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;

  // ALU operations
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

  // Immediate formats
  localparam logic [IMMSRC_W-1:0] IMM_I = 3'b000;
  localparam logic [IMMSRC_W-1:0] IMM_S = 3'b001;
  localparam logic [IMMSRC_W-1:0] IMM_B = 3'b010;
  localparam logic [IMMSRC_W-1:0] IMM_J = 3'b011;
  localparam logic [IMMSRC_W-1:0] IMM_U = 3'b100;

  // Result selects
  localparam logic [RESSRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RESSRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RESSRC_W-1:0] RES_PC4 = 2'b10;

  // ALU decode classes
  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;

  // Main-decoder output bundle
  typedef struct packed {
    logic                 reg_write;
    logic [IMMSRC_W-1:0]  imm_src;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic                 mem_write;
    logic [RESSRC_W-1:0]  result_src;
    logic                 branch;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 jump;
  } dec_t;

  // Controls carried from D into the E stage
  typedef struct packed {
    logic                 reg_write;
    logic [RESSRC_W-1:0]  result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 alu_src_a;
    logic                 alu_src_b;
  } ctrl_e_t;

endpackage

// File: rtl/aludec.sv
// ALU decode: maps ALUOp/funct3/funct7b5 to an ALU operation.
// Ports: op5 (opD[5]), funct3, funct7b5, alu_op in; alu_control out (comb).
module aludec
  import riscv_pkg::*;
(
  input  logic                 op5,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic [ALUOP_W-1:0]   alu_op,
  output logic [ALUCTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // Only R-type (op5=1) with funct7b5 subtracts; addi never does
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes in D and carries controls through the
// E, M and W pipeline registers; resolves branch/jump redirect in E.
// Ports: clk, rst (sync, active-high); opD/funct3D/funct7b5D decode fields;
// FlushE bubbles E; ZeroE ALU flag; ImmSrcD (comb); E controls; PCSrcE (comb);
// ResultSrcEb0 (load in E); MemWriteM, RegWriteM; RegWriteW, ResultSrcW.
module pipe_controller
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  output logic [IMMSRC_W-1:0]  ImmSrcD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic                 PCSrcE,
  output logic                 ResultSrcEb0,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [RESSRC_W-1:0]  ResultSrcW
);

  dec_t                 dec;
  logic [ALUCTRL_W-1:0] alu_control_d;
  ctrl_e_t              ctrl_d;
  ctrl_e_t              ctrl_e;
  logic [RESSRC_W-1:0]  result_src_m;

  // Main decoder; unknown opcodes fall through to all-zero controls
  always_comb begin
    dec = '0;
    case (opD)
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src_b  = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_SW: begin
        dec.imm_src    = IMM_S;
        dec.alu_src_b  = 1'b1;
        dec.mem_write  = 1'b1;
      end
      OP_RTYPE: begin
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALUOP_FUNC;
      end
      OP_BEQ: begin
        dec.imm_src    = IMM_B;
        dec.branch     = 1'b1;
        dec.alu_op     = ALUOP_SUB;
      end
      OP_IALU: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src_b  = 1'b1;
        dec.alu_op     = ALUOP_FUNC;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_U;
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  aludec u_aludec (
    .op5         (opD[5]),
    .funct3      (funct3D),
    .funct7b5    (funct7b5D),
    .alu_op      (dec.alu_op),
    .alu_control (alu_control_d)
  );

  assign ImmSrcD = dec.imm_src;

  assign ctrl_d = '{
    reg_write:   dec.reg_write,
    result_src:  dec.result_src,
    mem_write:   dec.mem_write,
    jump:        dec.jump,
    branch:      dec.branch,
    alu_control: alu_control_d,
    alu_src_a:   dec.alu_src_a,
    alu_src_b:   dec.alu_src_b
  };

  // D->E register; flush inserts a bubble, reset dominates
  always_ff @(posedge clk) begin
    if (rst || FlushE) ctrl_e <= '0;
    else               ctrl_e <= ctrl_d;
  end

  // E->M and M->W registers
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      result_src_m <= '0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= '0;
    end else begin
      RegWriteM    <= ctrl_e.reg_write;
      MemWriteM    <= ctrl_e.mem_write;
      result_src_m <= ctrl_e.result_src;
      RegWriteW    <= RegWriteM;
      ResultSrcW   <= result_src_m;
    end
  end

  assign ALUControlE  = ctrl_e.alu_control;
  assign ALUSrcAE     = ctrl_e.alu_src_a;
  assign ALUSrcBE     = ctrl_e.alu_src_b;
  assign ResultSrcEb0 = ctrl_e.result_src[0];
  assign PCSrcE       = (ctrl_e.branch & ZeroE) | ctrl_e.jump;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: expected per-instruction controls
// are pushed to a queue as each instruction is driven and compared as the
// instruction reaches the E, M and W outputs.
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D;
  logic       FlushE;
  logic       ZeroE;
  logic [2:0] ImmSrcD;
  logic [2:0] ALUControlE;
  logic       ALUSrcAE;
  logic       ALUSrcBE;
  logic       PCSrcE;
  logic       ResultSrcEb0;
  logic       MemWriteM;
  logic       RegWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;

  pipe_controller dut (
    .clk          (clk),
    .rst          (rst),
    .opD          (opD),
    .funct3D      (funct3D),
    .funct7b5D    (funct7b5D),
    .FlushE       (FlushE),
    .ZeroE        (ZeroE),
    .ImmSrcD      (ImmSrcD),
    .ALUControlE  (ALUControlE),
    .ALUSrcAE     (ALUSrcAE),
    .ALUSrcBE     (ALUSrcBE),
    .PCSrcE       (PCSrcE),
    .ResultSrcEb0 (ResultSrcEb0),
    .MemWriteM    (MemWriteM),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcW   (ResultSrcW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       jump;
    logic       branch;
    logic [2:0] alu;
    logic       sa;
    logic       sb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BEQ = 7'b1100011, IA = 7'b0010011, JAL = 7'b1101111,
                         LUI = 7'b0110111, NOP = 7'b0000000, BAD = 7'b1111111;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference table: {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, ALUOp, Jump}
  function automatic logic [12:0] ref_main(input logic [6:0] op);
    case (op)
      LW:      return 13'b1_000_0_1_0_01_0_00_0;
      SW:      return 13'b0_001_0_1_1_00_0_00_0;
      RT:      return 13'b1_000_0_0_0_00_0_10_0;
      BEQ:     return 13'b0_010_0_0_0_00_1_01_0;
      IA:      return 13'b1_000_0_1_0_00_0_10_0;
      JAL:     return 13'b1_011_0_0_0_10_0_00_1;
      LUI:     return 13'b1_100_1_1_0_00_0_00_0;
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [1:0] aop, input logic op5,
                                         input logic [2:0] f3, input logic f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // One decode cycle: drive D inputs, check D/E combinational outputs,
  // push expectation, then after the edge check E, M and W outputs.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic flush, input logic rstv, input logic z);
    logic [12:0] m;
    exp_t        e;
    exp_t        cur_e;
    @(negedge clk);
    opD = op; funct3D = f3; funct7b5D = f7; FlushE = flush; rst = rstv; ZeroE = z;
    #1;
    m = ref_main(op);
    check("ImmSrcD", 8'(ImmSrcD), 8'(m[11:9]));
    cur_e = exp_q[2];
    check("PCSrcE", 8'(PCSrcE), 8'((cur_e.branch & z) | cur_e.jump));

    e.rw     = m[12];
    e.sa     = m[8];
    e.sb     = m[7];
    e.mw     = m[6];
    e.rs     = m[5:4];
    e.branch = m[3];
    e.jump   = m[0];
    e.alu    = ref_alu(m[2:1], op[5], f3, f7);
    if (flush || rstv) e = '0;
    exp_q.push_back(e);
    if (exp_q.size() > 3) void'(exp_q.pop_front());
    if (rstv) begin
      exp_q[0] = '0;
      exp_q[1] = '0;
    end

    @(posedge clk);
    #1;
    check("ALUControlE",  8'(ALUControlE),  8'(exp_q[2].alu));
    check("ALUSrcAE",     8'(ALUSrcAE),     8'(exp_q[2].sa));
    check("ALUSrcBE",     8'(ALUSrcBE),     8'(exp_q[2].sb));
    check("ResultSrcEb0", 8'(ResultSrcEb0), 8'(exp_q[2].rs[0]));
    check("MemWriteM",    8'(MemWriteM),    8'(exp_q[1].mw));
    check("RegWriteM",    8'(RegWriteM),    8'(exp_q[1].rw));
    check("RegWriteW",    8'(RegWriteW),    8'(exp_q[0].rw));
    check("ResultSrcW",   8'(ResultSrcW),   8'(exp_q[0].rs));
  endtask

  initial begin
    rst = 1'b1; opD = NOP; funct3D = '0; funct7b5D = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) exp_q.push_back(exp_t'('0));

    // Reset held: everything must read zero
    step(NOP, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Main stream lw, sw, add, beq, addi, jal, lui then drain
    step(LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(BEQ, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(IA,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // sub vs addi with funct7b5 set, then remaining funct3 decodes
    step(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(IA, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    step(IA, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch taken/not taken, jal with ZeroE low
    step(BEQ, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(BEQ, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush while taken branch is in E: redirect now, bubble next cycle
    step(BEQ, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(IA,  3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load followed by flush: load visible in E, no write downstream
    step(LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill with sw/add then reset mid-flight
    step(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(RT, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Undefined opcode
    step(BAD, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(NOP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
